llbit_monitor: RTL

LLBIT_MONITOR -- requirements
Module: llbit_monitor

---
 rtl/llbit_pkg.sv | 21 ++
 rtl/llbit_entry.sv | 54 +++++
 rtl/llbit_monitor.sv | 94 +++++++++
 3 files changed

// File: rtl/llbit_pkg.sv
// Shared types for the LL/SC reservation monitor: per-channel entry state and
// the granule reduction used by every address comparison.
package llbit_pkg;

  localparam int unsigned GRAN_W = 64;
  localparam int unsigned AGE_W  = 32;

  typedef logic [GRAN_W-1:0] gran_t;

  typedef struct packed {
    logic             valid;
    gran_t            addr;
    logic [AGE_W-1:0] age;
  } entry_t;

  // Addresses are zero-extended to GRAN_W before reduction, so any ADDR_W up to 64 fits.
  function automatic gran_t granule(input gran_t addr, input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/llbit_entry.sv
// One channel's reservation: flush beats set, set beats every other clear,
// and an optional age counter retires stale reservations.
module llbit_entry
  import llbit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_flush,
  input  logic  i_set,
  input  gran_t i_set_gran,
  input  logic  i_clr,
  output logic  o_valid,
  output gran_t o_gran
);

  entry_t entry_q, entry_d;
  logic   expire;

  assign expire = (TIMEOUT != 0) && entry_q.valid
                  && (entry_q.age == AGE_W'(TIMEOUT - 1));

  always_comb begin
    entry_d = entry_q;
    if (i_flush) begin
      entry_d.valid = 1'b0;
      entry_d.age   = '0;
    end else if (i_set) begin
      entry_d.valid = 1'b1;
      entry_d.addr  = i_set_gran;
      entry_d.age   = '0;
    end else if (i_clr || expire) begin
      entry_d.valid = 1'b0;
      entry_d.age   = '0;
    end else if (!entry_q.valid || (TIMEOUT == 0)) begin
      entry_d.age   = '0;
    end else begin
      entry_d.age   = entry_q.age + AGE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign o_valid = entry_q.valid;
  assign o_gran  = entry_q.addr;

endmodule

// File: rtl/llbit_monitor.sv
// LL/SC reservation monitor: one entry per hardware thread, cleared by SCs,
// snooped stores from other threads, flushes and aging.
module llbit_monitor
  import llbit_pkg::*;
#(
  parameter int unsigned  N_CH     = 2,
  parameter int unsigned  ADDR_W   = 32,
  parameter int unsigned  GRAN_LSB = 2,
  parameter int unsigned  TIMEOUT  = 1024,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH-1:0]   i_flush,
  input  logic              i_ll_vld,
  input  logic [CH_W-1:0]   i_ll_ch,
  input  logic [ADDR_W-1:0] i_ll_addr,
  input  logic              i_sc_vld,
  input  logic [CH_W-1:0]   i_sc_ch,
  input  logic [ADDR_W-1:0] i_sc_addr,
  input  logic              i_st_vld,
  input  logic [CH_W-1:0]   i_st_ch,
  input  logic [ADDR_W-1:0] i_st_addr,
  output logic              o_sc_vld,
  output logic              o_sc_ok,
  output logic [N_CH-1:0]   o_llbit
);

  gran_t           ll_gran, sc_gran, st_gran;
  logic            ll_act, sc_act, st_act;
  logic [N_CH-1:0] ent_valid;
  gran_t           ent_gran [N_CH];
  logic            sc_vld_d, sc_vld_q;
  logic            sc_ok_d, sc_ok_q;

  assign ll_gran = granule(gran_t'(i_ll_addr), GRAN_LSB);
  assign sc_gran = granule(gran_t'(i_sc_addr), GRAN_LSB);
  assign st_gran = granule(gran_t'(i_st_addr), GRAN_LSB);

  // Out-of-range channel indices are dropped here so they never touch an entry.
  assign ll_act = i_ll_vld && (32'(i_ll_ch) < N_CH);
  assign sc_act = i_sc_vld && (32'(i_sc_ch) < N_CH);
  assign st_act = i_st_vld && (32'(i_st_ch) < N_CH);

  always_comb begin
    sc_ok_d = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (sc_act && (i_sc_ch == CH_W'(c))) begin
        sc_ok_d = ent_valid[c] && (ent_gran[c] == sc_gran) && !i_flush[c]
                  && !(st_act && (i_st_ch != CH_W'(c)) && (st_gran == ent_gran[c]));
      end
    end
  end

  assign sc_vld_d = i_sc_vld;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic set, clr;

    assign set = ll_act && (i_ll_ch == CH_W'(gi));
    // Own SC always consumes the reservation; a winning SC or a foreign store kills matching ones.
    assign clr = (sc_act && (i_sc_ch == CH_W'(gi)))
              || (sc_ok_d && (i_sc_ch != CH_W'(gi)) && (ent_gran[gi] == sc_gran))
              || (st_act && (i_st_ch != CH_W'(gi)) && (ent_gran[gi] == st_gran));

    llbit_entry #(
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_flush    (i_flush[gi]),
      .i_set      (set),
      .i_set_gran (ll_gran),
      .i_clr      (clr),
      .o_valid    (ent_valid[gi]),
      .o_gran     (ent_gran[gi])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sc_vld_q <= 1'b0;
      sc_ok_q  <= 1'b0;
    end else begin
      sc_vld_q <= sc_vld_d;
      sc_ok_q  <= sc_ok_d;
    end
  end

  assign o_sc_vld = sc_vld_q;
  assign o_sc_ok  = sc_ok_q;
  assign o_llbit  = ent_valid;

endmodule
